// File: rtl/systolic_pkg.sv
// systolic_pkg: shared types and field layout for the weight-stationary array sequencer
package systolic_pkg;
  typedef enum logic [2:0] {S_IDLE, S_WAIT_W, S_LOAD, S_COMPUTE, S_DRAIN, S_DONE} state_t;
  localparam int A_W = 4;
  localparam int W_W = 8;
  localparam int ACC_W = 32;
  localparam int MULT_LSB = 0;
  localparam int MULT_W = 4;
  localparam int SHIFT_LSB = 4;
  localparam int SHIFT_W = 4;
endpackage

// File: rtl/skew_line.sv
// skew_line: zero-reset shift register exposing its last TAPS stages (q[0] is the oldest-but-TAPS-1 stage)
module skew_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1,
  parameter int TAPS = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [WIDTH-1:0]            d,
  output logic [TAPS-1:0][WIDTH-1:0]  q
);
  logic [DEPTH-1:0][WIDTH-1:0] pipe;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pipe <= '0;
    else begin
      pipe[0] <= d;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign q = pipe[DEPTH-1 -: TAPS];
endmodule

// File: rtl/systolic_wgt_ctrl.sv
// systolic_wgt_ctrl: per-job sequencer that loads PE weights, streams skewed activations and drains the grid
module systolic_wgt_ctrl
  import systolic_pkg::*;
#(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int VEC_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [VEC_W-1:0]      num_vec,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  input  logic [8*COLS-1:0]     wt_data,
  input  logic                  wt_valid,
  output logic                  wt_ready,
  input  logic [4*ROWS-1:0]     act_data,
  input  logic                  act_valid,
  output logic                  act_ready,
  output logic                  arr_load_en,
  output logic [32*COLS-1:0]    arr_top_sum,
  output logic [4*ROWS-1:0]     arr_in_a,
  output logic [COLS-1:0]       res_valid
);
  localparam int BW = $clog2(ROWS + 1);
  localparam int DW = $clog2(ROWS + COLS + 1);
  state_t state, state_n;
  logic [VEC_W-1:0] nv, acc;
  logic [BW-1:0] beat;
  logic [DW-1:0] dcnt;
  logic accept_start, wt_fire, act_fire, last_beat, last_vec, drain_end, underrun;
  logic [A_W*ROWS-1:0] a_in;
  assign accept_start = state == S_IDLE && start;
  assign wt_ready = state == S_WAIT_W || state == S_LOAD;
  assign wt_fire = wt_ready && wt_valid;
  assign act_ready = state == S_COMPUTE && acc < nv;
  assign act_fire = act_ready && act_valid;
  assign underrun = state == S_LOAD && !wt_valid;
  assign last_beat = wt_fire && beat == BW'(ROWS - 1);
  assign last_vec = act_fire && acc == nv - VEC_W'(1);
  assign drain_end = state == S_DRAIN && dcnt == DW'(ROWS + COLS - 1);
  assign busy = state != S_IDLE;
  assign done = state == S_DONE;
  assign arr_load_en = wt_fire;
  // bubbles and idle cycles push zeros so the grid never sees stale nibbles
  assign a_in = act_fire ? act_data : '0;
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:           state_n = start ? S_WAIT_W : S_IDLE;
      S_WAIT_W, S_LOAD: state_n = underrun ? S_IDLE :
                                  last_beat ? (nv == '0 ? S_DONE : S_COMPUTE) :
                                  wt_fire ? S_LOAD : state;
      S_COMPUTE:        state_n = last_vec ? S_DRAIN : S_COMPUTE;
      S_DRAIN:          state_n = drain_end ? S_DONE : S_DRAIN;
      default:          state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nv <= '0;
      acc <= '0;
      beat <= '0;
      dcnt <= '0;
      err <= 1'b0;
    end else begin
      if (accept_start) begin
        nv <= num_vec;
        acc <= '0;
        beat <= '0;
        dcnt <= '0;
        err <= 1'b0;
      end
      if (underrun) err <= 1'b1;
      if (wt_fire) beat <= beat + 1'b1;
      if (act_fire) acc <= acc + 1'b1;
      if (state == S_DRAIN) dcnt <= dcnt + 1'b1;
    end
  end
  for (genvar c = 0; c < COLS; c++) begin : g_col
    assign arr_top_sum[c*ACC_W +: ACC_W] = wt_fire ? ACC_W'(wt_data[c*W_W +: W_W]) : '0;
  end
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    skew_line #(.DEPTH(r + 1), .WIDTH(A_W), .TAPS(1)) u_skew (
      .clk(clk), .rst_n(rst_n), .d(a_in[r*A_W +: A_W]), .q(arr_in_a[r*A_W +: A_W])
    );
  end
  // valid travels with the wavefront: column c result emerges ROWS+c+1 cycles after accept
  skew_line #(.DEPTH(ROWS + COLS), .WIDTH(1), .TAPS(COLS)) u_vpipe (
    .clk(clk), .rst_n(rst_n), .d(act_fire), .q(res_valid)
  );
endmodule

// File: tb/tb_systolic_wgt_ctrl.sv
// tb_systolic_wgt_ctrl: randomized job-level bench with a cycle-indexed accept map as reference
module tb_systolic_wgt_ctrl;
  localparam int ROWS = 4, COLS = 4, VEC_W = 16;
  logic clk = 0, rst_n = 0, start = 0, wt_valid = 0, act_valid = 0;
  logic [VEC_W-1:0] num_vec = '0;
  logic [8*COLS-1:0] wt_data = '0;
  logic [4*ROWS-1:0] act_data = '0;
  logic busy, done, err, wt_ready, act_ready, arr_load_en;
  logic [32*COLS-1:0] arr_top_sum;
  logic [4*ROWS-1:0] arr_in_a;
  logic [COLS-1:0] res_valid;
  int vecs = 0, errs = 0, cyc = 0;
  int res_cnt[COLS];
  logic exp_err = 0;
  logic [4*ROWS-1:0] acc_map [int];

  systolic_wgt_ctrl #(.ROWS(ROWS), .COLS(COLS), .VEC_W(VEC_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_vec(num_vec), .busy(busy), .done(done),
    .err(err), .wt_data(wt_data), .wt_valid(wt_valid), .wt_ready(wt_ready),
    .act_data(act_data), .act_valid(act_valid), .act_ready(act_ready),
    .arr_load_en(arr_load_en), .arr_top_sum(arr_top_sum), .arr_in_a(arr_in_a),
    .res_valid(res_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // row r shows the vector accepted r+1 cycles ago; column c is valid ROWS+c+1 cycles after accept
  task automatic settle();
    #1;
    for (int r = 0; r < ROWS; r++) begin
      logic [4*ROWS-1:0] v;
      v = acc_map.exists(cyc - 1 - r) ? acc_map[cyc - 1 - r] : '0;
      chk($sformatf("in_a[%0d]", r), arr_in_a[4*r +: 4], v[4*r +: 4]);
    end
    for (int c = 0; c < COLS; c++) begin
      chk($sformatf("res_valid[%0d]", c), res_valid[c], acc_map.exists(cyc - 1 - ROWS - c));
      if (res_valid[c]) res_cnt[c]++;
    end
  endtask

  task automatic ctl(input logic eb, ed, ee, ewr, ear, ele);
    logic [32*COLS-1:0] ts;
    for (int c = 0; c < COLS; c++) ts[32*c +: 32] = ele ? {24'b0, wt_data[8*c +: 8]} : 32'b0;
    chk("busy", busy, eb);
    chk("done", done, ed);
    chk("err", err, ee);
    chk("wt_ready", wt_ready, ewr);
    chk("act_ready", act_ready, ear);
    chk("load_en", arr_load_en, ele);
    chk("top_sum", arr_top_sum, ts);
  endtask

  task automatic nxt(input logic acc);
    if (acc) acc_map[cyc] = act_data;
    @(negedge clk);
  endtask

  task automatic run_job(input int nv, input int pre, input int gap, input logic [31:0] bub_mask,
                         input int bub_pct, input int rst_at, input logic fixed_wt, input logic drain_start);
    int acc, steps;
    logic bub, bubbled;
    for (int c = 0; c < COLS; c++) res_cnt[c] = 0;
    start = 1; num_vec = VEC_W'(nv);
    settle(); ctl(0, 0, exp_err, 0, 0, 0); nxt(0);
    start = 0; num_vec = VEC_W'($urandom); exp_err = 0;
    for (int i = 0; i < pre; i++) begin
      wt_valid = 0; wt_data = $urandom;
      settle(); ctl(1, 0, 0, 1, 0, 0); nxt(0);
    end
    for (int b = 0; b < ROWS; b++) begin
      if (b == gap) begin
        wt_valid = 0;
        settle(); ctl(1, 0, 0, 1, 0, 0); nxt(0);
        exp_err = 1;
        settle(); ctl(0, 0, 1, 0, 0, 0);
        return;
      end
      wt_valid = 1;
      wt_data = fixed_wt ? {COLS{8'(b + 1)}} : $urandom;
      settle(); ctl(1, 0, 0, 1, 0, 1); nxt(0);
    end
    wt_valid = 0;
    acc = 0; steps = 0; bubbled = 0;
    while (acc < nv) begin
      if (acc == rst_at) begin
        rst_n = 0;
        #1;
        ctl(0, 0, 0, 0, 0, 0);
        chk("rst_in_a", arr_in_a, '0);
        chk("rst_res_valid", res_valid, '0);
        @(negedge clk);
        acc_map.delete();
        rst_n = 1; act_valid = 0; exp_err = 0;
        return;
      end
      bub = steps < 4 * nv + 8 && ((bub_mask[acc] && !bubbled) || $urandom_range(99) < bub_pct);
      act_valid = !bub; act_data = $urandom;
      settle(); ctl(1, 0, 0, 0, 1, 0); nxt(!bub);
      if (bub) bubbled = 1;
      else begin acc++; bubbled = 0; end
      steps++;
    end
    act_valid = 0;
    if (nv > 0)
      for (int d = 0; d < ROWS + COLS; d++) begin
        start = drain_start && d == 2; num_vec = VEC_W'($urandom);
        settle(); ctl(1, 0, 0, 0, 0, 0); nxt(0);
        start = 0;
      end
    settle(); ctl(1, 1, 0, 0, 0, 0); nxt(0);
    settle(); ctl(0, 0, 0, 0, 0, 0);
    for (int c = 0; c < COLS; c++) chk($sformatf("res_cnt[%0d]", c), res_cnt[c], nv);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    settle(); ctl(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1;
    run_job(1, 0, -1, 0, 0, -1, 1, 0);
    run_job(8, 0, -1, 32'h48, 0, -1, 0, 0);
    run_job(3, 1, 2, 0, 0, -1, 0, 0);
    run_job(5, 2, -1, 0, 0, -1, 0, 0);
    run_job(0, 0, -1, 0, 0, -1, 0, 0);
    run_job(10, 0, -1, 0, 20, 4, 0, 0);
    run_job(6, 1, -1, 0, 0, -1, 0, 0);
    run_job(4, 0, -1, 0, 0, -1, 0, 1);
    repeat (12)
      run_job($urandom_range(1, 12), $urandom_range(0, 3), -1, 0, 30, -1, 0, 1'($urandom_range(0, 1)));
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/systolic_wgt_ctrl.md
# systolic_wgt_ctrl

Sequencer for a ROWS x COLS weight-stationary array of 4-bit-activation MAC PEs. It runs one job per start: loads one weight byte per PE through the column sum chains, streams `num_vec` activation vectors with row skew, drains the array, then pulses `done`. It sits between the weight/activation buffers and the PE grid and owns the grid's global `load_weight_en`.

## Interface
- ROWS, 4, PE rows (activation lanes)
- COLS, 4, PE columns (result lanes)
- VEC_W, 16, width of vector count
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low; shared with the PE grid
- start  in  1  job start; sampled in IDLE only
- num_vec  in  VEC_W  vectors in job; latched on start
- busy  out  1  high from cycle after accepted start until done cycle inclusive
- done  out  1  one-cycle pulse at job end
- err  out  1  sticky weight-underrun flag; cleared by accepted start
- wt_data  in  8*COLS  one weight row, byte c -> column c; [3:0] signed multiplier, [7:4] shift
- wt_valid  in  1  weight row valid
- wt_ready  out  1  weight row accepted when wt_valid&wt_ready
- act_data  in  4*ROWS  signed activation vector, nibble r -> row r
- act_valid  in  1  vector valid
- act_ready  out  1  vector accepted when act_valid&act_ready
- arr_load_en  out  1  to every PE load_weight_en
- arr_top_sum  out  32*COLS  to row-0 in_sum per column
- arr_in_a  out  4*ROWS  to column-0 in_a per row, skewed
- res_valid  out  COLS  bit c: bottom out_sum of column c holds a valid result this cycle

All outputs reset to 0.

## Operation
- States: IDLE, WAIT_W, LOAD, COMPUTE, DRAIN, DONE.
- IDLE: start -> latch num_vec, clear err, go WAIT_W.
- WAIT_W: wt_ready=1; first accepted row -> LOAD with beat counter=1.
- Weight rows arrive bottom row first (row ROWS-1), row 0 last. Each accepted beat drives arr_load_en=1 and arr_top_sum[c] = zero-extended wt_data byte c in the same cycle (combinational from accepted beat).
- LOAD: wt_ready=1; ROWS beats must be back-to-back because the grid cannot freeze. A wt_valid gap -> err=1, arr_load_en=0, go IDLE, no done.
- After beat ROWS: num_vec==0 -> DONE; else COMPUTE.
- COMPUTE: act_ready=1 while accepted<num_vec. arr_top_sum=0. Bubbles (act_valid=0) inject a zero vector marked invalid. Last accept -> DRAIN.
- DRAIN: inject zeros for ROWS+COLS cycles (flushes out_a/out_sum pipelines), then DONE.
- DONE: done=1 for one cycle, go IDLE.
- start outside IDLE is ignored.
- Reset mid-job: FSM to IDLE, skew and valid pipes cleared, err cleared.

## Timing
- Vector accepted in cycle T: row r nibble appears on arr_in_a in cycle T+1+r (row 0 through one register, row r through r+1).
- Column c result is on the bottom out_sum in cycle T+1+ROWS+c; res_valid[c] is high exactly then, only for accepted vectors.
- Garbage in out_sum after LOAD is never flagged valid.
- arr_load_en is never high while any vector is in flight.
- Job latency with full-rate streams: ROWS (load) + num_vec + ROWS+COLS (drain) + 1 (done) cycles after WAIT_W exit.

## Structure
- Package systolic_pkg holds: state enum; A_W=4, W_W=8, ACC_W=32; weight-byte field positions (MULT [3:0], SHIFT [7:4]).
- Sub-module skew_line (params DEPTH, WIDTH; zero-reset shift register):
  - one instance per row for activations, DEPTH=r+1;
  - one valid pipe of depth ROWS+COLS, tapped per column.

## Test plan
- ROWS=COLS=4, 4 back-to-back weight rows 0x01..0x04, num_vec=1, act nibbles all 1, accepted at T -> arr_load_en high 4 cycles; res_valid[0] at T+5, res_valid[3] at T+8; done once.
- num_vec=8 with act_valid low on vectors 3 and 6 for one cycle each -> exactly 8 res_valid pulses per column; bubble slots not flagged.
- wt_valid drops after 2 beats -> err=1, busy falls, no done; next start clears err.
- num_vec=0 -> 4 load cycles then done; act_ready never high; res_valid stays 0.
- rst_n asserted during COMPUTE -> all outputs 0 immediately; new job after release completes normally.
- start pulsed during DRAIN -> ignored; job count and num_vec unchanged.
